neo_68k_master: RTL
===================

# neo_68k_master

Synchronous 68000-style bus initiator that turns single-word requests from a local master (debug/DMA port or CPU-core wrapper) into asynchronous 68000 bus cycles. It drives address, RW, nAS, nUDS and nLDS toward the address decoder and cart/port logic, and waits on the returned nDTACK. It is the counterpart of the C1 decode/wait responder, and enforces a DTACK timeout so a missing responder cannot hang the requester.

## Interface
- TIMEOUT, default 255: wait-state clocks tolerated in WAIT before forced termination; 0 disables the timeout.
- CLK_68KCLK  in  1  clock, all state changes on rising edge
- nRESET  in  1  asynchronous active-low reset
- REQ  in  1  request strobe, sampled only in IDLE
- REQ_WE  in  1  1 = write, 0 = read
- REQ_ADDR  in  23  word address (A23..A1)
- REQ_BE  in  2  byte enables, [1] upper (nUDS), [0] lower (nLDS)
- REQ_WDATA  in  16  write data
- BUSY  out  1  high from acceptance through the S_END state
- ACK  out  1  one-clock completion pulse
- ERR  out  1  valid with ACK; 1 = timeout or illegal request
- RDATA  out  16  read data, valid with ACK
- M68K_ADDR  out  23  bus address A23..A1
- M68K_DATA_OUT  out  16  write data
- M68K_DATA_OE  out  1  data drive enable
- M68K_DATA_IN  in  16  read data from bus
- RW, nAS, nUDS, nLDS  out  1 each  68000 bus strobes
- nDTACK  in  1  cycle acknowledge, active low

## Operation
- States: IDLE, S_ADDR, S_STROBE, S_WAIT, S_END.
- IDLE with REQ=1 and REQ_BE≠00: capture REQ_WE/ADDR/BE/WDATA, go to S_ADDR.
- IDLE with REQ=1 and REQ_BE=00: no bus activity. Pulse ACK with ERR=1 and RDATA=0 in the next clock. Stay IDLE.
- S_ADDR: M68K_ADDR driven with captured address; nAS, nUDS, nLDS and RW all high. Next state S_STROBE.
- S_STROBE: nAS low.
  - Read: the enabled data strobes go low.
  - Write: RW low, M68K_DATA_OE=1, data strobes stay high.
  - Next state S_WAIT.
- S_WAIT: nAS low, the enabled strobes low (read and write), RW and OE held.
  - nDTACK is sampled only in S_WAIT; a low nDTACK during S_STROBE is ignored.
  - nDTACK=0 at the edge: go to S_END.
  - Otherwise increment the wait counter. When the counter reaches TIMEOUT (TIMEOUT≠0): go to S_END with the error flag set.
- S_END: strobes held as in S_WAIT.
  - On the exit edge, RDATA is loaded: M68K_DATA_IN for a read without error, 0 for a write or an error.
  - ACK=1 and ERR=error flag are set on the same edge. Next state IDLE.
- IDLE: nAS/nUDS/nLDS/RW high, OE=0. M68K_ADDR and M68K_DATA_OUT hold their last values.
- Byte writes: M68K_DATA_OUT carries the enabled byte on both halves.
  - BE=10: {WDATA[15:8], WDATA[15:8]}.
  - BE=01: {WDATA[7:0], WDATA[7:0]}.
  - BE=11: WDATA unchanged.
- Byte reads: RDATA is the full 16-bit bus value; the requester selects the byte.
- Wait counter: 8 bits, cleared on entry to S_ADDR, saturates, never wraps.
- No read-modify-write cycles and no bus arbitration.

## Timing
- Reset values: nAS=nUDS=nLDS=RW=1, M68K_DATA_OE=0, M68K_ADDR=0, M68K_DATA_OUT=0, RDATA=0, BUSY=ACK=ERR=0, state IDLE, counter 0.
- Reset asserted mid-cycle: all strobes release and OE drops immediately (asynchronous). No ACK is generated for the aborted request.
- Edge numbering: acceptance edge = E0. S_ADDR after E0, S_STROBE after E1, S_WAIT after E2.
- With nDTACK low at E3: S_END after E3, ACK and RDATA valid in the clock after E4. This is the minimum access: 4 clocks from acceptance to ACK edge.
- Each clock of nDTACK high in S_WAIT adds one clock.
- Timeout: ACK follows TIMEOUT+1 sampled-high clocks in S_WAIT, plus one clock for S_END.
- The ACK clock is spent in IDLE, so a new REQ may be accepted during the ACK clock. Back-to-back period is 5 clocks minimum.
- BUSY=1 from the clock after E0 until the ACK clock; BUSY=0 while ACK=1.
- RDATA holds until the next ACK. ERR is meaningful only while ACK=1 and is 0 otherwise.

## Test plan
- Read 0x100000 (REQ_ADDR=0x080000), BE=11, responder drives nDTACK low immediately and data 0xBEEF -> nAS low for exactly 3 clocks, ACK 4 clocks after acceptance, RDATA=0xBEEF, ERR=0.
- Write 0x12AB to 0x200000 with BE=01, nDTACK delayed 3 clocks -> nUDS stays high, nLDS low in S_WAIT/S_END only, DATA_OUT=0xABAB, RW low from S_STROBE to S_END, ACK 7 clocks after acceptance.
- TIMEOUT=4, nDTACK held high -> ACK with ERR=1, RDATA=0, strobes release, next request is still accepted normally.
- REQ_BE=00 -> nAS never asserts, ACK+ERR one clock after REQ.
- nRESET asserted during S_WAIT of a write -> nAS/nLDS/RW high and OE=0 within the same clock, no ACK, first request after reset completes normally.
- Two requests back-to-back with REQ held -> second nAS falls exactly 5 clocks after the first, and nDTACK low during S_STROBE is ignored.

Source files
------------

// File: rtl/neo_68k_master.sv
// 68000-style bus initiator: converts single-word local requests into 68000 bus
// cycles. A DTACK timeout guarantees that every accepted request completes.
module neo_68k_master #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        CLK_68KCLK,
  input  logic        nRESET,
  input  logic        REQ,
  input  logic        REQ_WE,
  input  logic [22:0] REQ_ADDR,
  input  logic [1:0]  REQ_BE,
  input  logic [15:0] REQ_WDATA,
  output logic        BUSY,
  output logic        ACK,
  output logic        ERR,
  output logic [15:0] RDATA,
  output logic [22:0] M68K_ADDR,
  output logic [15:0] M68K_DATA_OUT,
  output logic        M68K_DATA_OE,
  input  logic [15:0] M68K_DATA_IN,
  output logic        RW,
  output logic        nAS,
  output logic        nUDS,
  output logic        nLDS,
  input  logic        nDTACK
);

  typedef enum logic [2:0] {
    IDLE,
    S_ADDR,
    S_STROBE,
    S_WAIT,
    S_END
  } stateT;

  localparam logic [7:0] TimeoutCount = 8'(TIMEOUT);
  localparam bit         TimeoutOn    = (TIMEOUT != 0);

  stateT       state;
  logic        weReg;
  logic [1:0]  beReg;
  logic [7:0]  waitCnt;
  logic        errFlag;
  logic [15:0] wdataLane;

  // Byte writes replicate the enabled byte onto both halves of the data bus.
  always_comb begin
    wdataLane = REQ_WDATA;
    case (REQ_BE)
      2'b10:   wdataLane = {REQ_WDATA[15:8], REQ_WDATA[15:8]};
      2'b01:   wdataLane = {REQ_WDATA[7:0], REQ_WDATA[7:0]};
      default: wdataLane = REQ_WDATA;
    endcase
  end

  // Bus cycle sequencer; all bus strobes and status outputs are registered here.
  always_ff @(posedge CLK_68KCLK or negedge nRESET) begin
    if (!nRESET) begin
      state         <= IDLE;
      weReg         <= 1'b0;
      beReg         <= 2'b00;
      waitCnt       <= 8'd0;
      errFlag       <= 1'b0;
      BUSY          <= 1'b0;
      ACK           <= 1'b0;
      ERR           <= 1'b0;
      RDATA         <= 16'd0;
      M68K_ADDR     <= 23'd0;
      M68K_DATA_OUT <= 16'd0;
      M68K_DATA_OE  <= 1'b0;
      RW            <= 1'b1;
      nAS           <= 1'b1;
      nUDS          <= 1'b1;
      nLDS          <= 1'b1;
    end else begin
      ACK <= 1'b0;
      ERR <= 1'b0;
      case (state)
        IDLE: begin
          if (REQ) begin
            if (REQ_BE != 2'b00) begin
              state     <= S_ADDR;
              weReg     <= REQ_WE;
              beReg     <= REQ_BE;
              M68K_ADDR <= REQ_ADDR;
              if (REQ_WE) begin
                M68K_DATA_OUT <= wdataLane;
              end
              waitCnt <= 8'd0;
              errFlag <= 1'b0;
              BUSY    <= 1'b1;
            end else begin
              // A request with no byte enabled is refused without touching the bus.
              ACK   <= 1'b1;
              ERR   <= 1'b1;
              RDATA <= 16'd0;
            end
          end
        end

        S_ADDR: begin
          state <= S_STROBE;
          nAS   <= 1'b0;
          if (weReg) begin
            RW           <= 1'b0;
            M68K_DATA_OE <= 1'b1;
          end else begin
            nUDS <= ~beReg[1];
            nLDS <= ~beReg[0];
          end
        end

        S_STROBE: begin
          state <= S_WAIT;
          nUDS  <= ~beReg[1];
          nLDS  <= ~beReg[0];
        end

        // The wait counter saturates so a disabled timeout can never wrap around.
        S_WAIT: begin
          if (!nDTACK) begin
            state <= S_END;
          end else begin
            if (TimeoutOn && (waitCnt == TimeoutCount)) begin
              state   <= S_END;
              errFlag <= 1'b1;
            end
            if (waitCnt != 8'hFF) begin
              waitCnt <= waitCnt + 8'd1;
            end
          end
        end

        S_END: begin
          state        <= IDLE;
          ACK          <= 1'b1;
          ERR          <= errFlag;
          RDATA        <= (!weReg && !errFlag) ? M68K_DATA_IN : 16'd0;
          BUSY         <= 1'b0;
          nAS          <= 1'b1;
          nUDS         <= 1'b1;
          nLDS         <= 1'b1;
          RW           <= 1'b1;
          M68K_DATA_OE <= 1'b0;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
